// File: rtl/trees_sched.sv
// trees_sched: command-driven sequencer in front of the tree-ensemble engine.
//   LOAD_MODEL streams N_TREES*N_NODE_AND_LEAFS node words into the engine's tree memory.
//   INFER packs N_FEATURE/2 feature-pair beats per sample, pulses start, and collects
//   each prediction into a small result FIFO.
// Optional feature: define TREES_SCHED_DBUF_EN to add a shadow feature buffer.
//   With it, the next sample is prefetched while the engine evaluates the current one.
//
// Handshakes: every stream (cmd, in, res) transfers on a rising clock edge where
// valid && ready; ready never depends on valid, and valid is never withdrawn by this
// block once raised (res_valid drops only through a pop).
module trees_sched #(
   parameter int N_TREES          = 16,
   parameter int N_NODE_AND_LEAFS = 256,
   parameter int N_FEATURE        = 32,
   parameter int RES_DEPTH        = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                cmd_valid,
   output logic                                cmd_ready,
   input  logic                                cmd_op,
   input  logic [15:0]                         cmd_count,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [63:0]                         in_data,
   output logic                                load_trees,
   output logic [$clog2(N_TREES)-1:0]          n_tree,
   output logic [$clog2(N_NODE_AND_LEAFS)-1:0] n_node,
   output logic [63:0]                         tree_nodes,
   output logic [N_FEATURE*32-1:0]             features,
   output logic                                start,
   input  logic [7:0]                          prediction,
   input  logic                                done,
   output logic                                res_valid,
   input  logic                                res_ready,
   output logic [7:0]                          res_data,
   output logic                                busy
);

   localparam int TW   = $clog2(N_TREES);
   localparam int NW   = $clog2(N_NODE_AND_LEAFS);
   localparam int LW   = TW + NW;
   localparam int HALF = N_FEATURE / 2;
   localparam int FCW  = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int AW   = $clog2(RES_DEPTH);
   localparam int CW   = AW + 1;

   localparam logic [LW-1:0]  LAST_LOAD = LW'(N_TREES * N_NODE_AND_LEAFS - 1);
   localparam logic [FCW-1:0] LAST_BEAT = FCW'(HALF - 1);

   // S_PREF is only reachable when the shadow buffer is built in.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FEAT  = 3'd2,
      S_START = 3'd3,
      S_WAIT  = 3'd4,
      S_PREF  = 3'd5
   } state_t;

   state_t          state;
   logic [LW-1:0]   load_cnt;
   logic [FCW-1:0]  feat_cnt;
   logic [15:0]     remaining;

   // result FIFO storage and bookkeeping
   logic [7:0]      mem [RES_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   rd_ptr_inc;
   logic [CW-1:0]   fifo_cnt;

   logic            cmd_fire;
   logic            in_fire;
   logic            pop;
   logic            push;
   logic            fifo_space;

   assign cmd_fire   = cmd_valid && cmd_ready;
   assign in_fire    = in_valid && in_ready;
   assign pop        = res_valid && res_ready;
   assign push       = (state == S_WAIT) && done;
   // a pop in the same cycle frees a slot for this start
   assign fifo_space = (fifo_cnt != CW'(RES_DEPTH)) || pop;
   assign rd_ptr_inc = rd_ptr + AW'(1);

   assign cmd_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign res_valid  = (fifo_cnt != '0);

`ifdef TREES_SCHED_DBUF_EN
   localparam int PCW = $clog2(HALF + 1);

   logic [N_FEATURE*32-1:0] shadow;
   logic [N_FEATURE*32-1:0] shadow_nxt;
   logic [PCW-1:0]          pref_cnt;
   logic [PCW-1:0]          pref_cnt_nxt;
   logic                    pref_open;
   logic                    pref_beat;
   logic                    pref_full_nxt;

   // prefetch only while a further sample is still owed after the current one
   assign pref_open     = (state == S_WAIT) && (remaining > 16'd1) && (pref_cnt != PCW'(HALF));
   assign in_ready      = (state == S_LOAD) || (state == S_FEAT) || pref_open || (state == S_PREF);
   assign pref_beat     = in_fire && ((state == S_WAIT) || (state == S_PREF));
   assign pref_cnt_nxt  = pref_cnt + PCW'(pref_beat);
   assign pref_full_nxt = (pref_cnt_nxt == PCW'(HALF));

   // shadow contents including the beat accepted this cycle
   always_comb begin
      shadow_nxt = shadow;
      if (pref_beat) begin
         shadow_nxt[{pref_cnt[FCW-1:0], 6'b0} +: 64] = in_data;
      end
   end
`else
   assign in_ready = (state == S_LOAD) || (state == S_FEAT);
`endif

   // sequencer FSM with registered engine-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         load_cnt   <= '0;
         feat_cnt   <= '0;
         remaining  <= '0;
         load_trees <= 1'b0;
         n_tree     <= '0;
         n_node     <= '0;
         tree_nodes <= '0;
         features   <= '0;
         start      <= 1'b0;
`ifdef TREES_SCHED_DBUF_EN
         shadow     <= '0;
         pref_cnt   <= '0;
`endif
      end else begin
         load_trees <= 1'b0;
         start      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_fire) begin
                  if (!cmd_op) begin
                     load_cnt <= '0;
                     state    <= S_LOAD;
                  end else if (cmd_count != 16'd0) begin
                     remaining <= cmd_count;
                     feat_cnt  <= '0;
                     state     <= S_FEAT;
                  end
               end
            end
            S_LOAD: begin
               if (in_fire) begin
                  load_trees       <= 1'b1;
                  {n_tree, n_node} <= load_cnt;
                  tree_nodes       <= in_data;
                  load_cnt         <= load_cnt + LW'(1);
                  if (load_cnt == LAST_LOAD) begin
                     state <= S_IDLE;
                  end
               end
            end
            S_FEAT: begin
               if (in_fire) begin
                  features[{feat_cnt, 6'b0} +: 64] <= in_data;
                  feat_cnt <= feat_cnt + FCW'(1);
                  if (feat_cnt == LAST_BEAT) begin
                     feat_cnt <= '0;
                     state    <= S_START;
                  end
               end
            end
            S_START: begin
               if (fifo_space) begin
                  start <= 1'b1;
                  state <= S_WAIT;
`ifdef TREES_SCHED_DBUF_EN
                  pref_cnt <= '0;
`endif
               end
            end
            S_WAIT: begin
`ifdef TREES_SCHED_DBUF_EN
               if (pref_beat) begin
                  shadow   <= shadow_nxt;
                  pref_cnt <= pref_cnt_nxt;
               end
`endif
               if (done) begin
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     state <= S_IDLE;
                  end else begin
`ifdef TREES_SCHED_DBUF_EN
                     if (pref_full_nxt) begin
                        features <= shadow_nxt;
                        state    <= S_START;
                     end else begin
                        state <= S_PREF;
                     end
`else
                     state <= S_FEAT;
`endif
                  end
               end
            end
`ifdef TREES_SCHED_DBUF_EN
            S_PREF: begin
               if (pref_beat) begin
                  shadow   <= shadow_nxt;
                  pref_cnt <= pref_cnt_nxt;
                  if (pref_full_nxt) begin
                     features <= shadow_nxt;
                     state    <= S_START;
                  end
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   // result FIFO storage; contents need no reset, occupancy is tracked separately
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= prediction;
      end
   end

   // result FIFO pointers, occupancy and registered head (held when empty)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         res_data <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (pop) begin
            if (fifo_cnt > CW'(1)) begin
               res_data <= mem[rd_ptr_inc];
            end else if (push) begin
               res_data <= prediction;
            end
         end else if ((fifo_cnt == '0) && push) begin
            res_data <= prediction;
         end
      end
   end

endmodule
